// File: rtl/fft_but4_pkg.sv
// Shared definitions for the radix-4 iterative FFT address generators.
//   calc_n / calc_aw / calc_bw / calc_sw : size and width derivations from STAGES
//   stage_span                           : log2 of the butterfly span at stage s
//   TW_ROM_DEPTH                         : twiddle ROM depth for the default size
//   state_t                              : run/idle state of the generator
package fft_but4_pkg;

    // Transform size N = 4^stages.
    function automatic int unsigned calc_n(input int unsigned stages);
        return 32'd1 << (2 * stages);
    endfunction

    // Data / twiddle address width, log2(N).
    function automatic int unsigned calc_aw(input int unsigned stages);
        return 2 * stages;
    endfunction

    // Butterfly index width, log2(N/4).
    function automatic int unsigned calc_bw(input int unsigned stages);
        return 2 * stages - 2;
    endfunction

    // Smallest stage-counter width that can hold stages-1.
    function automatic int unsigned calc_sw(input int unsigned stages);
        for (int unsigned w = 1; w < 32; w++) begin
            if ((32'd1 << w) >= stages) return w;
        end
        return 32;
    endfunction

    // Shift amount giving span = 4^(stages-1-s); out-of-range stages map to 0.
    function automatic int unsigned stage_span(input int unsigned stages,
                                               input int unsigned s);
        if (s < stages) return 2 * (stages - 1 - s);
        return 0;
    endfunction

    localparam int unsigned DEFAULT_STAGES = 3;
    localparam int unsigned TW_ROM_DEPTH   = calc_n(DEFAULT_STAGES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fft_but4_addr_map.sv
// Combinational radix-4 DIF address map for butterfly b of stage s.
//   b, s             : butterfly index and stage
//   RD_ADDR0..3      : in-place data addresses base + k*span
//   TW_ADDR1..3      : twiddle indices k * j * 4^s
// span = 4^(STAGES-1-s), j = b mod span, base = 4*span*(b/span) + j,
// all formed with shifts and masks.
module fft_but4_addr_map
    import fft_but4_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned AW     = calc_aw(STAGES),
    parameter int unsigned BW     = calc_bw(STAGES),
    parameter int unsigned SW     = 2
) (
    input  logic [BW-1:0] b,
    input  logic [SW-1:0] s,
    output logic [AW-1:0] RD_ADDR0,
    output logic [AW-1:0] RD_ADDR1,
    output logic [AW-1:0] RD_ADDR2,
    output logic [AW-1:0] RD_ADDR3,
    output logic [AW-1:0] TW_ADDR1,
    output logic [AW-1:0] TW_ADDR2,
    output logic [AW-1:0] TW_ADDR3
);

    int unsigned   sh;
    int unsigned   tsh;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] span;
    logic [AW-1:0] j;
    logic [AW-1:0] base;
    logic [AW-1:0] jt;

    always_comb begin
        sh    = stage_span(STAGES, 32'(s));
        tsh   = 2 * 32'(s);
        b_ext = AW'(b);
        span  = AW'(1) << sh;
        j     = b_ext & (span - AW'(1));
        // group index b>>sh lands at 4*span*g, i.e. shifted up by sh+2
        base  = ((b_ext >> sh) << (sh + 2)) | j;
        RD_ADDR0 = base;
        RD_ADDR1 = base + span;
        RD_ADDR2 = base + (span << 1);
        RD_ADDR3 = base + span + (span << 1);
        // j*4^s < N/4, so 3*j*4^s never wraps
        jt       = j << tsh;
        TW_ADDR1 = jt;
        TW_ADDR2 = jt << 1;
        TW_ADDR3 = jt + (jt << 1);
    end

endmodule

// File: rtl/fft_iter_addr_gen_but4.sv
// Butterfly address generator for the iterative radix-4 DIF FFT.
//   CLK, RST        : clock, synchronous active-high reset
//   EN              : clock enable, all state holds when low
//   START           : begin a new transform (restarts if already busy)
//   BUT_STROB       : capture current read addresses as write addresses
//   ADDR_EN         : advance to the next butterfly
//   RD_ADDR0..3     : read addresses of the current butterfly
//   WR_ADDR0..3     : write addresses of the butterfly being written
//   TW_ADDR1..3     : twiddle ROM indices for legs 1..3
//   FIRST_STAGE, LAST_STAGE, BUSY, DONE : status flags
module fft_iter_addr_gen_but4
    import fft_but4_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned AW     = calc_aw(STAGES),
    parameter int unsigned BW     = calc_bw(STAGES),
    parameter int unsigned SW     = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          START,
    input  logic          BUT_STROB,
    input  logic          ADDR_EN,
    output logic [AW-1:0] RD_ADDR0,
    output logic [AW-1:0] RD_ADDR1,
    output logic [AW-1:0] RD_ADDR2,
    output logic [AW-1:0] RD_ADDR3,
    output logic [AW-1:0] WR_ADDR0,
    output logic [AW-1:0] WR_ADDR1,
    output logic [AW-1:0] WR_ADDR2,
    output logic [AW-1:0] WR_ADDR3,
    output logic [AW-1:0] TW_ADDR1,
    output logic [AW-1:0] TW_ADDR2,
    output logic [AW-1:0] TW_ADDR3,
    output logic          FIRST_STAGE,
    output logic          LAST_STAGE,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [SW-1:0] LAST_S = SW'(STAGES - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    logic [SW-1:0] s_q, s_d;
    logic          done_q, done_d;

    // Addresses depend only on the registered counters.
    fft_but4_addr_map #(
        .STAGES(STAGES),
        .AW    (AW),
        .BW    (BW),
        .SW    (SW)
    ) u_map (
        .b       (b_q),
        .s       (s_q),
        .RD_ADDR0(RD_ADDR0),
        .RD_ADDR1(RD_ADDR1),
        .RD_ADDR2(RD_ADDR2),
        .RD_ADDR3(RD_ADDR3),
        .TW_ADDR1(TW_ADDR1),
        .TW_ADDR2(TW_ADDR2),
        .TW_ADDR3(TW_ADDR3)
    );

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_d     = s_q;
        done_d  = 1'b0;
        if (START) begin
            state_d = ST_RUN;
            b_d     = '0;
            s_d     = '0;
        end else if (ADDR_EN && (state_q == ST_RUN)) begin
            if (b_q != '1) begin
                b_d = b_q + BW'(1);
            end else if (s_q != LAST_S) begin
                b_d = '0;
                s_d = s_q + SW'(1);
            end else begin
                b_d     = '0;
                s_d     = '0;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            s_q     <= '0;
            done_q  <= 1'b0;
        end else if (EN) begin
            state_q <= state_d;
            b_q     <= b_d;
            s_q     <= s_d;
            done_q  <= done_d;
        end
    end

    // Captured on the same edge ADDR_EN advances b, so the write phase keeps
    // the old butterfly's addresses while the read side moves on.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WR_ADDR0 <= '0;
            WR_ADDR1 <= '0;
            WR_ADDR2 <= '0;
            WR_ADDR3 <= '0;
        end else if (EN && BUT_STROB) begin
            WR_ADDR0 <= RD_ADDR0;
            WR_ADDR1 <= RD_ADDR1;
            WR_ADDR2 <= RD_ADDR2;
            WR_ADDR3 <= RD_ADDR3;
        end
    end

    assign BUSY        = (state_q == ST_RUN);
    assign DONE        = done_q;
    assign FIRST_STAGE = BUSY && (s_q == '0);
    assign LAST_STAGE  = BUSY && (s_q == LAST_S);

endmodule

// File: tb/tb_fft_iter_addr_gen_but4.sv
// Self-checking bench for fft_iter_addr_gen_but4 (STAGES=3, N=64).
module tb_fft_iter_addr_gen_but4;

    localparam int ST = 3;
    localparam int N  = 64;
    localparam int Q  = N / 4;

    logic       CLK = 1'b0;
    logic       RST, EN, START, BUT_STROB, ADDR_EN;
    logic [5:0] RD_ADDR0, RD_ADDR1, RD_ADDR2, RD_ADDR3;
    logic [5:0] WR_ADDR0, WR_ADDR1, WR_ADDR2, WR_ADDR3;
    logic [5:0] TW_ADDR1, TW_ADDR2, TW_ADDR3;
    logic       FIRST_STAGE, LAST_STAGE, BUSY, DONE;

    fft_iter_addr_gen_but4 #(.STAGES(ST), .AW(6), .BW(4), .SW(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START),
        .BUT_STROB(BUT_STROB), .ADDR_EN(ADDR_EN),
        .RD_ADDR0(RD_ADDR0), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2), .RD_ADDR3(RD_ADDR3),
        .WR_ADDR0(WR_ADDR0), .WR_ADDR1(WR_ADDR1), .WR_ADDR2(WR_ADDR2), .WR_ADDR3(WR_ADDR3),
        .TW_ADDR1(TW_ADDR1), .TW_ADDR2(TW_ADDR2), .TW_ADDR3(TW_ADDR3),
        .FIRST_STAGE(FIRST_STAGE), .LAST_STAGE(LAST_STAGE), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mb, ms, mwr[4];
    bit mbusy, mdone;

    function automatic int span_of(int s);
        return 1 << (2 * (ST - 1 - s));
    endfunction

    function automatic int exp_rd(int b, int s, int k);
        int sp;
        sp = span_of(s);
        return (b / sp) * 4 * sp + (b % sp) + k * sp;
    endfunction

    function automatic int exp_tw(int b, int s, int k);
        return k * (b % span_of(s)) * (1 << (2 * s));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit en, input bit st, input bit ae, input bit bs, input bit rst);
        EN = en; START = st; ADDR_EN = ae; BUT_STROB = bs; RST = rst;
    endtask

    task automatic model_edge();
        if (RST) begin
            mb = 0; ms = 0; mbusy = 0; mdone = 0;
            for (int k = 0; k < 4; k++) mwr[k] = 0;
        end else if (EN) begin
            if (BUT_STROB)
                for (int k = 0; k < 4; k++) mwr[k] = exp_rd(mb, ms, k);
            mdone = 0;
            if (START) begin
                mb = 0; ms = 0; mbusy = 1;
            end else if (ADDR_EN && mbusy) begin
                if (mb < Q - 1) mb++;
                else if (ms < ST - 1) begin mb = 0; ms++; end
                else begin mb = 0; ms = 0; mbusy = 0; mdone = 1; end
            end
        end
    endtask

    task automatic verify();
        int rd[4], wr[4], tw[4];
        rd = '{RD_ADDR0, RD_ADDR1, RD_ADDR2, RD_ADDR3};
        wr = '{WR_ADDR0, WR_ADDR1, WR_ADDR2, WR_ADDR3};
        tw = '{0, TW_ADDR1, TW_ADDR2, TW_ADDR3};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd%0d", k), rd[k], exp_rd(mb, ms, k));
            check($sformatf("wr%0d", k), wr[k], mwr[k]);
            if (k > 0) check($sformatf("tw%0d", k), tw[k], exp_tw(mb, ms, k));
        end
        check("busy", BUSY, mbusy);
        check("done", DONE, mdone);
        check("first_stage", FIRST_STAGE, mbusy && ms == 0);
        check("last_stage", LAST_STAGE, mbusy && ms == ST - 1);
    endtask

    // Inputs are stable across the edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        verify();
    endtask

    task automatic start_and_pulse(input int n);
        set_in(1, 1, 0, 0, 0); tick();
        set_in(1, 0, 1, 0, 0);
        repeat (n) tick();
        set_in(1, 0, 0, 0, 0); tick();
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 1); tick(); tick();
        set_in(1, 0, 0, 0, 0);
    endtask

    typedef struct {
        int pulses;
        int rd0, rd1, rd2, rd3;
        int tw1, tw2, tw3;
        bit first, last;
    } vec_t;

    vec_t vecs[6];
    int   seen[ST][N];
    int   bad;

    initial begin
        // Known-answer table: ADDR_EN pulses after START -> expected outputs
        vecs[0] = '{0,   0, 16, 32, 48,  0,  0,  0, 1'b1, 1'b0};
        vecs[1] = '{5,   5, 21, 37, 53,  5, 10, 15, 1'b1, 1'b0};
        vecs[2] = '{15, 15, 31, 47, 63, 15, 30, 45, 1'b1, 1'b0};
        vecs[3] = '{21, 17, 21, 25, 29,  4,  8, 12, 1'b0, 1'b0};
        vecs[4] = '{37, 20, 21, 22, 23,  0,  0,  0, 1'b0, 1'b1};
        vecs[5] = '{47, 60, 61, 62, 63,  0,  0,  0, 1'b0, 1'b1};

        mb = 0; ms = 0; mbusy = 0; mdone = 0;
        for (int k = 0; k < 4; k++) mwr[k] = 0;

        do_reset();
        check("reset_busy", BUSY, 0);
        check("reset_rd1", RD_ADDR1, 16);
        check("reset_tw1", TW_ADDR1, 0);

        for (int i = 0; i < 6; i++) begin
            start_and_pulse(vecs[i].pulses);
            check($sformatf("vec%0d_rd0", i), RD_ADDR0, vecs[i].rd0);
            check($sformatf("vec%0d_rd1", i), RD_ADDR1, vecs[i].rd1);
            check($sformatf("vec%0d_rd2", i), RD_ADDR2, vecs[i].rd2);
            check($sformatf("vec%0d_rd3", i), RD_ADDR3, vecs[i].rd3);
            check($sformatf("vec%0d_tw1", i), TW_ADDR1, vecs[i].tw1);
            check($sformatf("vec%0d_tw2", i), TW_ADDR2, vecs[i].tw2);
            check($sformatf("vec%0d_tw3", i), TW_ADDR3, vecs[i].tw3);
            check($sformatf("vec%0d_first", i), FIRST_STAGE, vecs[i].first);
            check($sformatf("vec%0d_last", i), LAST_STAGE, vecs[i].last);
            check($sformatf("vec%0d_busy", i), BUSY, 1);
        end

        // Full transform with per-stage coverage scoreboard
        for (int s = 0; s < ST; s++)
            for (int a = 0; a < N; a++) seen[s][a] = 0;
        set_in(1, 1, 0, 0, 0); tick();
        set_in(1, 0, 1, 0, 0);
        for (int p = 0; p < ST * Q; p++) begin
            seen[ms][RD_ADDR0]++; seen[ms][RD_ADDR1]++;
            seen[ms][RD_ADDR2]++; seen[ms][RD_ADDR3]++;
            tick();
        end
        check("full_done", DONE, 1);
        check("full_busy", BUSY, 0);
        check("full_rd0", RD_ADDR0, 0);
        set_in(1, 0, 0, 0, 0); tick();
        check("full_done_pulse", DONE, 0);
        for (int s = 0; s < ST; s++) begin
            bad = 0;
            for (int a = 0; a < N; a++) if (seen[s][a] != 1) bad++;
            check($sformatf("coverage_stage%0d", s), bad, 0);
        end

        // DONE holds while EN is low, clears on the next enabled edge
        start_and_pulse(ST * Q - 1);
        set_in(1, 0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0); tick(); tick();
        check("done_hold_en0", DONE, 1);
        set_in(1, 0, 0, 0, 0); tick();
        check("done_clear", DONE, 0);

        // Write-address capture at s=0,b=7 on the advancing edge
        start_and_pulse(7);
        set_in(1, 0, 1, 1, 0); tick();
        set_in(1, 0, 0, 0, 0); tick();
        check("wr0_hold", WR_ADDR0, 7);
        check("wr1_hold", WR_ADDR1, 23);
        check("wr2_hold", WR_ADDR2, 39);
        check("wr3_hold", WR_ADDR3, 55);
        check("rd0_moved", RD_ADDR0, 8);
        check("rd3_moved", RD_ADDR3, 56);

        // START wins over ADDR_EN mid-stage 1
        start_and_pulse(20);
        set_in(1, 1, 1, 0, 0); tick();
        check("restart_rd1", RD_ADDR1, 16);
        check("restart_first", FIRST_STAGE, 1);
        check("restart_done", DONE, 0);
        // RST wins over START
        set_in(1, 1, 0, 0, 1); tick();
        check("rst_start_busy", BUSY, 0);

        // EN low freezes state
        set_in(1, 0, 0, 0, 0);
        start_and_pulse(3);
        set_in(0, 1, 1, 0, 0); tick(); tick(); tick();
        check("en0_rd0", RD_ADDR0, 3);

        // ADDR_EN while idle is ignored; BUT_STROB still captures
        do_reset();
        set_in(1, 0, 1, 1, 0); tick(); tick(); tick();
        check("idle_busy", BUSY, 0);
        check("idle_done", DONE, 0);
        check("idle_rd0", RD_ADDR0, 0);
        check("idle_wr1", WR_ADDR1, 16);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            set_in($urandom_range(9, 0) != 0,
                   $urandom_range(299, 0) == 0,
                   $urandom_range(9, 0) < 6,
                   $urandom_range(9, 0) < 3,
                   $urandom_range(399, 0) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
